// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall/flush controller for the five-stage in-order pipeline:
//            load-use bubbles, mispredict squash, fence drain, perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 decode_valid_in,
    input  logic [8:0]           decode_rs1_in,
    input  logic [8:0]           decode_rs2_in,
    input  logic                 execute_valid_in,
    input  logic                 execute_mem_read_in,
    input  logic [8:0]           execute_rd_in,
    input  logic                 mem_valid_in,
    input  logic                 mem_fence_in,
    input  logic                 mem_busy_in,
    input  logic                 store_pending_in,
    input  logic                 branch_mispredicted_in,
    output logic                 fetch_stall_out,
    output logic                 decode_stall_out,
    output logic                 execute_stall_out,
    output logic                 mem_stall_out,
    output logic                 fetch_flush_out,
    output logic                 decode_flush_out,
    output logic                 execute_flush_out,
    output logic [CNT_WIDTH-1:0] stall_count_out,
    output logic [CNT_WIDTH-1:0] flush_count_out
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FENCE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 pending_q, pending_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

    logic w_load_use;
    logic w_service;
    logic w_fence_entry;
    logic w_stall_all;
    logic w_stall_front;
    logic w_flush_front;
    logic w_flush_ex;

    assign w_load_use = execute_valid_in && execute_mem_read_in &&
                        (execute_rd_in != 9'd0) && decode_valid_in &&
                        ((execute_rd_in == decode_rs1_in) ||
                         (execute_rd_in == decode_rs2_in));

    // A mispredict seen while fencing is illegal ordering; it waits for RUN.
    assign w_service     = (branch_mispredicted_in || pending_q) && (state_q == RUN);
    assign w_fence_entry = mem_valid_in && mem_fence_in && store_pending_in;

    always_comb begin
        w_stall_all   = 1'b0;
        w_stall_front = 1'b0;
        w_flush_front = 1'b0;
        w_flush_ex    = 1'b0;
        state_d       = state_q;
        pending_d     = pending_q;
        flush_count_d = flush_count_q;

        if (reset) begin
            w_flush_front = 1'b1;
            w_flush_ex    = 1'b1;
        end else if (mem_busy_in) begin
            w_stall_all = 1'b1;
            if (branch_mispredicted_in) begin
                pending_d = 1'b1;
            end
        end else if (w_service) begin
            w_flush_front = 1'b1;
            w_flush_ex    = 1'b1;
            pending_d     = 1'b0;
            flush_count_d = flush_count_q + CNT_WIDTH'(1);
        end else if (state_q == FENCE) begin
            if (branch_mispredicted_in) begin
                pending_d = 1'b1;
            end
            if (store_pending_in) begin
                w_stall_all = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (w_fence_entry) begin
            w_stall_all = 1'b1;
            state_d     = FENCE;
        end else if (w_load_use) begin
            w_stall_front = 1'b1;
            w_flush_ex    = 1'b1;
        end

        stall_count_d = stall_count_q;
        if (w_stall_all || w_stall_front) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pending_q     <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_stall_out   = w_stall_all || w_stall_front;
    assign decode_stall_out  = w_stall_all || w_stall_front;
    assign execute_stall_out = w_stall_all;
    assign mem_stall_out     = w_stall_all;
    assign fetch_flush_out   = w_flush_front;
    assign decode_flush_out  = w_flush_front;
    assign execute_flush_out = w_flush_ex;
    assign stall_count_out   = stall_count_q;
    assign flush_count_out   = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed and random checks of pipeline_ctrl against a reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_v, ex_v, ex_mr, mv, mf, busy, st_pend, mp;
    logic [8:0] rs1, rs2, ex_rd;

    logic        fs, ds, es, ms, ff, df, ef;
    logic [31:0] scnt, fcnt;
    logic        fs4, ds4, es4, ms4, ff4, df4, ef4;
    logic [3:0]  scnt4, fcnt4;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit          m_fence;
    bit          m_pending;
    int unsigned m_scnt;
    int unsigned m_fcnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset),
        .decode_valid_in(dec_v), .decode_rs1_in(rs1), .decode_rs2_in(rs2),
        .execute_valid_in(ex_v), .execute_mem_read_in(ex_mr), .execute_rd_in(ex_rd),
        .mem_valid_in(mv), .mem_fence_in(mf), .mem_busy_in(busy),
        .store_pending_in(st_pend), .branch_mispredicted_in(mp),
        .fetch_stall_out(fs), .decode_stall_out(ds), .execute_stall_out(es),
        .mem_stall_out(ms), .fetch_flush_out(ff), .decode_flush_out(df),
        .execute_flush_out(ef), .stall_count_out(scnt), .flush_count_out(fcnt)
    );

    pipeline_ctrl #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .decode_valid_in(dec_v), .decode_rs1_in(rs1), .decode_rs2_in(rs2),
        .execute_valid_in(ex_v), .execute_mem_read_in(ex_mr), .execute_rd_in(ex_rd),
        .mem_valid_in(mv), .mem_fence_in(mf), .mem_busy_in(busy),
        .store_pending_in(st_pend), .branch_mispredicted_in(mp),
        .fetch_stall_out(fs4), .decode_stall_out(ds4), .execute_stall_out(es4),
        .mem_stall_out(ms4), .fetch_flush_out(ff4), .decode_flush_out(df4),
        .execute_flush_out(ef4), .stall_count_out(scnt4), .flush_count_out(fcnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dec_v = 0; ex_v = 0; ex_mr = 0; mv = 0; mf = 0;
        busy = 0; st_pend = 0; mp = 0;
        rs1 = 0; rs2 = 0; ex_rd = 0;
    endtask

    function automatic logic [6:0] expected_out();
        bit lu, svc;
        lu  = ex_v && ex_mr && (ex_rd != 0) && dec_v && (ex_rd == rs1 || ex_rd == rs2);
        svc = (mp || m_pending) && !m_fence;
        // {fetch_stall, decode_stall, ex_stall, mem_stall, fetch_flush, dec_flush, ex_flush}
        if (reset)                     return 7'b0000_111;
        else if (busy)                 return 7'b1111_000;
        else if (svc)                  return 7'b0000_111;
        else if (m_fence)              return st_pend ? 7'b1111_000 : 7'b0000_000;
        else if (mv && mf && st_pend)  return 7'b1111_000;
        else if (lu)                   return 7'b1100_001;
        else                           return 7'b0000_000;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, ":scnt"},  scnt, m_scnt);
        check({tag, ":fcnt"},  fcnt, m_fcnt);
        check({tag, ":scnt4"}, {28'd0, scnt4}, m_scnt & 32'hF);
        check({tag, ":fcnt4"}, {28'd0, fcnt4}, m_fcnt & 32'hF);
    endtask

    // Inputs are already applied; check outputs mid-cycle, then clock and check counters.
    task automatic step(input string tag);
        logic [6:0] e;
        bit svc;
        #2;
        e   = expected_out();
        svc = (mp || m_pending) && !m_fence;
        check({tag, ":out"}, {25'd0, fs, ds, es, ms, ff, df, ef}, {25'd0, e});
        @(posedge clk);
        if (reset) begin
            m_fence = 0; m_pending = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (e[5]) m_scnt++;
            if (busy) begin
                if (mp) m_pending = 1;
            end else if (svc) begin
                m_pending = 0;
                m_fcnt++;
            end else if (m_fence) begin
                if (mp) m_pending = 1;
                if (!st_pend) m_fence = 0;
            end else if (mv && mf && st_pend) begin
                m_fence = 1;
            end
        end
        #1;
        check_counts(tag);
    endtask

    initial begin
        idle();
        reset = 1;
        m_fence = 0; m_pending = 0; m_scnt = 0; m_fcnt = 0;
        #3;
        check("reset_out", {25'd0, fs, ds, es, ms, ff, df, ef}, 32'h07);
        check_counts("reset");
        step("reset_hold");
        reset = 0;
        step("post_reset");

        // load-use on rs2
        ex_v = 1; ex_mr = 1; ex_rd = 5; dec_v = 1; rs1 = 7; rs2 = 5;
        step("load_use");
        idle();
        step("after_lu");

        // load to x0 never stalls
        ex_v = 1; ex_mr = 1; ex_rd = 0; dec_v = 1; rs1 = 0; rs2 = 3;
        step("load_x0");

        // mispredict deferred by a 3-cycle busy bus
        idle();
        busy = 1; mp = 1;
        step("defer_0");
        mp = 0;
        step("defer_1");
        step("defer_2");
        busy = 0;
        step("defer_flush");
        step("defer_done");

        // fence drain: 4 stall cycles then release
        mv = 1; mf = 1; st_pend = 1;
        for (int i = 0; i < 4; i++) step("fence_hold");
        st_pend = 0;
        step("fence_exit");
        idle();
        step("fence_run");

        // fence with empty store buffer
        mv = 1; mf = 1; st_pend = 0;
        step("fence_empty");
        idle();

        // mispredict and load-use together: flush wins
        ex_v = 1; ex_mr = 1; ex_rd = 9; dec_v = 1; rs1 = 9; mp = 1;
        step("mp_and_lu");
        idle();

        // mispredict during FENCE is held until RUN
        mv = 1; mf = 1; st_pend = 1;
        step("fmp_enter");
        mp = 1;
        step("fmp_latch");
        mp = 0; st_pend = 0;
        step("fmp_exit");
        idle();
        step("fmp_service");
        step("fmp_idle");

        // asynchronous reset inside FENCE with pending set
        mv = 1; mf = 1; st_pend = 1;
        step("rst_fence_enter");
        busy = 1; mp = 1;
        step("rst_pend_set");
        mp = 0;
        reset = 1;
        #1;
        check("async_rst_out", {25'd0, fs, ds, es, ms, ff, df, ef}, 32'h07);
        check("async_rst_scnt", scnt, 32'd0);
        check("async_rst_fcnt", fcnt, 32'd0);
        step("rst_hold");
        reset = 0;
        idle();
        step("rst_release");

        // counter wrap at 4 bits: 17 stall cycles
        busy = 1;
        for (int i = 0; i < 17; i++) step("wrap");
        check("wrap_scnt4", {28'd0, scnt4}, 32'd1);
        check("wrap_scnt", scnt, 32'd17);
        idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            busy    = ($urandom_range(0, 4) == 0);
            mp      = ($urandom_range(0, 7) == 0);
            mv      = 1'($urandom_range(0, 1));
            mf      = ($urandom_range(0, 3) == 0);
            st_pend = 1'($urandom_range(0, 1));
            dec_v   = 1'($urandom_range(0, 1));
            ex_v    = 1'($urandom_range(0, 1));
            ex_mr   = 1'($urandom_range(0, 1));
            ex_rd   = 9'($urandom_range(0, 3));
            rs1     = 9'($urandom_range(0, 3));
            rs2     = 9'($urandom_range(0, 3));
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage in-order pipeline. It takes hazard and status information from decode, execute, memory and the bus interface, and drives the per-stage `stall_in`/`flush_in` controls of fetch, decode, execute and memory. Its duties:
- Load-use bubble insertion.
- Branch-mispredict squashing, with deferral while the data bus is busy.
- Holding the pipeline on a fence until the store path drains.

It also keeps stall and flush event counters for performance CSRs.

## Interface
Parameters:
- `CNT_WIDTH`, default 32: width of the performance counters.

Ports:
- `clk` input 1: pipeline clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `decode_valid_in` input 1: decode stage holds a valid instruction.
- `decode_rs1_in` input 9: decode-stage rs1 index.
- `decode_rs2_in` input 9: decode-stage rs2 index.
- `execute_valid_in` input 1: execute output register is valid.
- `execute_mem_read_in` input 1: execute output register holds a load.
- `execute_rd_in` input 9: execute output register destination.
- `mem_valid_in` input 1: memory stage instruction is valid.
- `mem_fence_in` input 1: memory stage instruction is a fence.
- `mem_busy_in` input 1: data bus transaction in progress.
- `store_pending_in` input 1: store buffer is not empty.
- `branch_mispredicted_in` input 1: memory stage resolved a misprediction this cycle.
- `fetch_stall_out`, `decode_stall_out`, `execute_stall_out`, `mem_stall_out` output 1 each: per-stage stall.
- `fetch_flush_out`, `decode_flush_out`, `execute_flush_out` output 1 each: per-stage flush.
- `stall_count_out` output `CNT_WIDTH`: number of cycles with `decode_stall_out`=1.
- `flush_count_out` output `CNT_WIDTH`: number of mispredict flushes serviced.

## Operation
- State: `RUN` / `FENCE`, plus the `mispredict_pending` flop.
- Stall/flush outputs are combinational from the inputs, the state and `pending`. They are evaluated in strict priority order:
  1. **reset=1:** all flushes=1, all stalls=0.
  2. **mem_busy_in=1:** all four stalls=1, flushes=0. If `branch_mispredicted_in`=1, set `pending` at the edge.
  3. **Mispredict service** (`branch_mispredicted_in` or `pending`): fetch, decode and execute flush=1, stalls=0. `pending` clears at the edge, and `flush_count` increments by 1.
  4. **FENCE state:**
     - If `store_pending_in`=1: all four stalls=1.
     - If `store_pending_in`=0: stalls=0, next state is `RUN`.
  5. **RUN fence entry** (`mem_valid_in` & `mem_fence_in` & `store_pending_in`): all four stalls=1 in the same cycle; next state is `FENCE`. A fence with `store_pending_in`=0 passes without a stall.
  6. **Load-use:** condition is `execute_valid_in` & `execute_mem_read_in` & (`execute_rd_in`≠0) & `decode_valid_in` & (`execute_rd_in`==`decode_rs1_in` or `execute_rd_in`==`decode_rs2_in`). Response: fetch and decode stall=1, `execute_flush_out`=1, execute and mem stall=0. Exactly one bubble is inserted.
  7. **Otherwise:** all outputs 0.
- A mispredict arriving in `FENCE` (illegal per pipeline ordering) is latched into `pending` and serviced on the first `RUN` cycle.
- Counters:
  - `stall_count` increments on every cycle with `decode_stall_out`=1.
  - Both counters wrap modulo 2^`CNT_WIDTH`.
  - Counters are not reset by flushes.

## Timing
- Reset values:
  - State=`RUN`, `pending`=0, `stall_count`=0, `flush_count`=0.
  - All stall outputs 0 and all flush outputs 1 while reset is asserted; flush outputs drop in the first cycle after deassertion.
- Latency:
  - Stall/flush outputs have zero-cycle latency (combinational, same cycle as their cause).
  - State, `pending` and counters update at the next rising edge.
- Deferred mispredict: the flush appears in the first cycle where `mem_busy_in`=0, at the earliest one cycle after the mispredict cycle.
- Reset mid-`FENCE` or with `pending`=1: returns to `RUN` with `pending` cleared immediately (asynchronous).
- Mispredict and load-use in the same cycle: the flush wins; no stall is asserted and `stall_count` does not increment.
- A stall asserted on every cycle of a `FENCE` lasting N cycles adds N to `stall_count`.

## Test plan
- **Load-use:** `execute_mem_read_in`=1, `execute_rd_in`=5, `decode_rs2_in`=5, both valid → for one cycle fetch/decode stall=1 and `execute_flush_out`=1; `stall_count` goes 0→1.
- **Load to x0:** same as above but `execute_rd_in`=0 with `decode_rs1_in`=0 → all outputs 0.
- **Mispredict deferral:** mispredict pulse while `mem_busy_in`=1 for 3 cycles → 3 cycles with all stalls=1 and no flush; fetch/decode/execute flush=1 in the 4th cycle; `flush_count`=1; `pending` cleared.
- **Fence drain:** fence in mem with `store_pending_in`=1 for 4 cycles → all stalls=1 for 4 cycles; 5th cycle stalls=0; state back to `RUN`; `stall_count`=4.
- **Fence with empty store buffer** → no stall, state stays `RUN`.
- **Reset and wrap:**
  - Assert `reset` asynchronously during `FENCE` with `pending`=1 → immediately all flushes=1, stalls=0; after release the state is `RUN` and the counters are 0.
  - Preload `CNT_WIDTH`=4, apply 17 stall cycles → `stall_count_out`=1.
